decode_stage: RTL and testbench
===============================

# decode_stage

Registered, handshaked RV32I decode stage: the next generation of the combinational decoder. It decodes the full RV32I base set (OP, OP-IMM, LUI, AUIPC, JAL, JALR, all six branches, all loads and stores) and holds the result in an output pipeline register, with an optional skid entry and flush support. It sits between instruction fetch and the register-read/execute stage.

## Interface
- `SKID_ENABLE`, default 1: 1 gives a two-entry skid buffer, so `o_ready` is purely registered. 0 gives a single entry with `o_ready = !o_valid || i_ready`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  reset; asynchronous and active-high.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  stage can accept an instruction this cycle.
- `i_instruction`  in  32 (`t_data`)  instruction word.
- `i_pc`  in  32 (`t_data`)  address of the instruction.
- `i_flush`  in  1  discard all held and incoming instructions.
- `o_valid`  out  1  decoded payload valid.
- `i_ready`  in  1  downstream accepts the payload.
- `o_pc`  out  32  forwarded PC.
- `o_source_register1`, `o_source_register2`, `o_destination_register`  out  5 each (`t_register_index`)  register indices.
- `o_destination_register_write_enable`  out  1  destination register write enable.
- `o_alu_operation`  out  `t_alu_operation`  operation selector for the ALU.
- `o_immediate`  out  32  sign-extended I/S/B/U/J immediate.
- `o_use_immediate`  out  1  ALU operand B is the immediate rather than source register 2.
- `o_use_pc`  out  1  ALU operand A is the PC (AUIPC, JAL).
- `o_branch_condition`  out  `t_branch_condition`  branch condition, or NONE/JUMP/JUMP_REG.
- `o_memory_read_enable`, `o_memory_write_enable`  out  1 each  memory access enables.
- `o_memory_size`  out  `t_memory_size`  BYTE, HALF or WORD.
- `o_memory_unsigned`  out  1  zero-extend the loaded value (LBU, LHU).
- `o_illegal`  out  1  instruction is not a recognised RV32I encoding.

## Operation
- **Transfers.** An input transfer happens on `i_valid && o_ready`. An output transfer happens on `o_valid && i_ready`.
- **Decode.** Decoding is combinational on `i_instruction` and is captured into the main entry, or into the skid entry when the main entry is held.
- **OP.** Decoded by funct3 plus funct7. funct7 is 0000000 for all ops, or 0100000 for SUB and SRA only. Any other funct7 is illegal.
- **OP-IMM.** SLLI and SRLI/SRAI require imm[11:5] to be 0000000, or 0100000 for SRAI. The immediate is the 5-bit shamt, zero-extended.
- **LUI.** The ALU adds x0 (rs1 index forced to 0) to the U-immediate.
- **AUIPC.** `o_use_pc=1`, ALU_OP_ADD, U-immediate.
- **JAL/JALR.** Condition is JUMP or JUMP_REG. Destination write is enabled; the writeback value is PC+4. JALR requires funct3 000.
- **BRANCH.** funct3 maps to EQ, NE, LT, GE, LTU, GEU. funct3 010 and 011 are illegal. ALU_OP_SUB; the B-immediate is carried for target computation.
- **LOAD/STORE.** ALU_OP_ADD with `o_use_immediate=1`. Loads accept funct3 000/001/010/100/101. Stores accept funct3 000/001/010. Everything else is illegal.
- **Illegal instructions.** `o_illegal=1`, all enables 0, branch condition NONE, ALU_OP_INVALID. The instruction is still transferred, so a downstream stage can raise the trap.
- **Skid (SKID_ENABLE=1).** The stage has two states:
  - EMPTY_OR_MAIN: the skid entry is empty and `o_ready=1`.
  - SKID_FULL: the skid entry is occupied and `o_ready=0`.
  - The skid entry fills when the main entry is valid, is not accepted downstream, and an input transfer occurs.
  - On the next output transfer the skid entry moves into main, and the stage returns to EMPTY_OR_MAIN.
- **Ordering.** Order is strictly preserved; no instruction is lost or duplicated.

## Timing
- **Latency.** One cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1.
- **Throughput.** One instruction per cycle when `i_ready=1`.
- **Reset.** While `i_reset` is high the following apply asynchronously:
  - `o_valid=0`, `o_ready=1`.
  - All payload outputs are 0, with enumerated outputs at ALU_OP_INVALID, BRANCH_NONE and BYTE.
  - The skid entry is emptied.
  - Reset asserted mid-stream drops every held instruction.
- **Flush.** `i_flush` in cycle N has these effects:
  - Both entries are invalid in N+1.
  - An instruction presented in N is discarded, even if `o_ready=1`.
  - Any downstream transfer in cycle N still completes.
  - `o_ready=1` in N+1.
- **Simultaneous in and out transfer** with the main entry full: the main entry is replaced by the new instruction; the skid entry is not used.
- **Stability.** Outputs remain stable while `o_valid && !i_ready`.

## Structure
- **`definitions` package additions:**
  - `t_alu_operation`: SUB, SLT, SLTU, SHIFT_* and the rest of the ALU ops.
  - `t_branch_condition`: EQ, NE, LT, GE, LTU, GEU, JUMP, JUMP_REG, NONE.
  - `t_memory_size`.
  - Opcode localparams.
  - A packed struct `t_decoded` holding the full payload.
- **Sub-module `instruction_decode`:** purely combinational, maps the instruction word to `t_decoded`. `decode_stage` holds only the registers and the handshake.

## Test plan
- **ADDI.** 0xFFB10093 (addi x1,x2,-5) → next cycle: `o_valid=1`, rs1=2, rd=1, imm=0xFFFFFFFB, ADD, `o_use_immediate=1`, write enable 1.
- **SRAI.** 0x40325193 (srai x3,x4,3) → imm=3, SHIFT_RIGHT_ARITH. Then 0x409403B3 (sub x7,x8,x9) → SUB, rs2=9, `o_use_immediate=0`.
- **Load.** 0x00832283 (lw x5,8(x6)) → `o_memory_read_enable=1`, size WORD, imm=8, unsigned 0. Then 0x00000000 → `o_illegal=1`, all enables 0.
- **Backpressure.** Stream 4 instructions with `i_ready=0` from the second cycle → `o_ready` falls after 2 are held. Raising `i_ready` then yields all 4 in order with none lost.
- **Flush.** `i_flush` with both entries full and `i_valid=1` → next cycle `o_valid=0` and `o_ready=1`; none of the three instructions ever appears.
- **Reset.** Assert `i_reset` asynchronously mid-stream → outputs reset before the next edge. Repeat the backpressure test with SKID_ENABLE=0 and check `o_ready` equals `!o_valid || i_ready` every cycle.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared types and opcode constants for the RV32I decode stage
package decode_stage_pkg;

  typedef logic [31:0] t_data;
  typedef logic [4:0]  t_register_index;

  // Reset/illegal values are encoded as 0 so a cleared payload reads as INVALID/NONE/BYTE.
  typedef enum logic [3:0] {
    ALU_OP_INVALID,
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_SLT,
    ALU_OP_SLTU,
    ALU_OP_XOR,
    ALU_OP_OR,
    ALU_OP_AND,
    ALU_OP_SHIFT_LEFT,
    ALU_OP_SHIFT_RIGHT,
    ALU_OP_SHIFT_RIGHT_ARITH
  } t_alu_operation;

  typedef enum logic [3:0] {
    BRANCH_NONE,
    BRANCH_EQ,
    BRANCH_NE,
    BRANCH_LT,
    BRANCH_GE,
    BRANCH_LTU,
    BRANCH_GEU,
    BRANCH_JUMP,
    BRANCH_JUMP_REG
  } t_branch_condition;

  typedef enum logic [1:0] {
    MEMORY_SIZE_BYTE,
    MEMORY_SIZE_HALF,
    MEMORY_SIZE_WORD
  } t_memory_size;

  typedef enum logic {
    ST_EMPTY_OR_MAIN,
    ST_SKID_FULL
  } t_skid_state;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

  typedef struct packed {
    t_register_index   source_register1;
    t_register_index   source_register2;
    t_register_index   destination_register;
    logic              destination_register_write_enable;
    t_alu_operation    alu_operation;
    t_data             immediate;
    logic              use_immediate;
    logic              use_pc;
    t_branch_condition branch_condition;
    logic              memory_read_enable;
    logic              memory_write_enable;
    t_memory_size      memory_size;
    logic              memory_unsigned;
    logic              illegal;
  } t_decoded;

  typedef struct packed {
    t_data    pc;
    t_decoded decoded;
  } t_entry;

endpackage

// File: rtl/decode_stage_instruction_decode.sv
// rtl/decode_stage_instruction_decode.sv - combinational RV32I instruction word to payload decoder
module instruction_decode
  import decode_stage_pkg::*;
(
  input  t_data    i_instruction,
  output t_decoded o_decoded
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  t_data      imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic       illegal;
  t_decoded   d;

  assign opcode = i_instruction[6:0];
  assign funct3 = i_instruction[14:12];
  assign funct7 = i_instruction[31:25];
  assign imm_i  = {{20{i_instruction[31]}}, i_instruction[31:20]};
  assign imm_s  = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign imm_b  = {{20{i_instruction[31]}}, i_instruction[7], i_instruction[30:25], i_instruction[11:8], 1'b0};
  assign imm_u  = {i_instruction[31:12], 12'b0};
  assign imm_j  = {{12{i_instruction[31]}}, i_instruction[19:12], i_instruction[20], i_instruction[30:21], 1'b0};
  assign shamt  = {27'b0, i_instruction[24:20]};

  always_comb begin
    illegal = 1'b0;
    d       = '0;
    case (opcode)
      OPCODE_OP: begin
        d.source_register1                  = i_instruction[19:15];
        d.source_register2                  = i_instruction[24:20];
        d.destination_register              = i_instruction[11:7];
        d.destination_register_write_enable = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: d.alu_operation = ALU_OP_ADD;
          10'b0100000_000: d.alu_operation = ALU_OP_SUB;
          10'b0000000_001: d.alu_operation = ALU_OP_SHIFT_LEFT;
          10'b0000000_010: d.alu_operation = ALU_OP_SLT;
          10'b0000000_011: d.alu_operation = ALU_OP_SLTU;
          10'b0000000_100: d.alu_operation = ALU_OP_XOR;
          10'b0000000_101: d.alu_operation = ALU_OP_SHIFT_RIGHT;
          10'b0100000_101: d.alu_operation = ALU_OP_SHIFT_RIGHT_ARITH;
          10'b0000000_110: d.alu_operation = ALU_OP_OR;
          10'b0000000_111: d.alu_operation = ALU_OP_AND;
          default:         illegal = 1'b1;
        endcase
      end
      OPCODE_OP_IMM: begin
        d.source_register1                  = i_instruction[19:15];
        d.destination_register              = i_instruction[11:7];
        d.destination_register_write_enable = 1'b1;
        d.use_immediate                     = 1'b1;
        d.immediate                         = imm_i;
        case (funct3)
          3'b000: d.alu_operation = ALU_OP_ADD;
          3'b010: d.alu_operation = ALU_OP_SLT;
          3'b011: d.alu_operation = ALU_OP_SLTU;
          3'b100: d.alu_operation = ALU_OP_XOR;
          3'b110: d.alu_operation = ALU_OP_OR;
          3'b111: d.alu_operation = ALU_OP_AND;
          3'b001: begin
            d.alu_operation = ALU_OP_SHIFT_LEFT;
            d.immediate     = shamt;
            illegal         = (funct7 != 7'b0000000);
          end
          default: begin
            // Bit 30 selects arithmetic; every other imm[11:5] bit must be zero.
            d.alu_operation = funct7[5] ? ALU_OP_SHIFT_RIGHT_ARITH : ALU_OP_SHIFT_RIGHT;
            d.immediate     = shamt;
            illegal         = ((funct7 & 7'b1011111) != 7'b0000000);
          end
        endcase
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        d.destination_register              = i_instruction[11:7];
        d.destination_register_write_enable = 1'b1;
        d.use_immediate                     = 1'b1;
        d.use_pc                            = (opcode == OPCODE_AUIPC);
        d.alu_operation                     = ALU_OP_ADD;
        d.immediate                         = imm_u;
      end
      OPCODE_JAL: begin
        d.destination_register              = i_instruction[11:7];
        d.destination_register_write_enable = 1'b1;
        d.use_immediate                     = 1'b1;
        d.use_pc                            = 1'b1;
        d.alu_operation                     = ALU_OP_ADD;
        d.immediate                         = imm_j;
        d.branch_condition                  = BRANCH_JUMP;
      end
      OPCODE_JALR: begin
        d.source_register1                  = i_instruction[19:15];
        d.destination_register              = i_instruction[11:7];
        d.destination_register_write_enable = 1'b1;
        d.use_immediate                     = 1'b1;
        d.alu_operation                     = ALU_OP_ADD;
        d.immediate                         = imm_i;
        d.branch_condition                  = BRANCH_JUMP_REG;
        illegal                             = (funct3 != 3'b000);
      end
      OPCODE_BRANCH: begin
        d.source_register1 = i_instruction[19:15];
        d.source_register2 = i_instruction[24:20];
        d.alu_operation    = ALU_OP_SUB;
        d.immediate        = imm_b;
        case (funct3)
          3'b000:  d.branch_condition = BRANCH_EQ;
          3'b001:  d.branch_condition = BRANCH_NE;
          3'b100:  d.branch_condition = BRANCH_LT;
          3'b101:  d.branch_condition = BRANCH_GE;
          3'b110:  d.branch_condition = BRANCH_LTU;
          3'b111:  d.branch_condition = BRANCH_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        d.source_register1                  = i_instruction[19:15];
        d.destination_register              = i_instruction[11:7];
        d.destination_register_write_enable = 1'b1;
        d.use_immediate                     = 1'b1;
        d.alu_operation                     = ALU_OP_ADD;
        d.immediate                         = imm_i;
        d.memory_read_enable                = 1'b1;
        d.memory_size                       = t_memory_size'(funct3[1:0]);
        d.memory_unsigned                   = funct3[2];
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
          default:                                 illegal = 1'b1;
        endcase
      end
      OPCODE_STORE: begin
        d.source_register1    = i_instruction[19:15];
        d.source_register2    = i_instruction[24:20];
        d.use_immediate       = 1'b1;
        d.alu_operation       = ALU_OP_ADD;
        d.immediate           = imm_s;
        d.memory_write_enable = 1'b1;
        d.memory_size         = t_memory_size'(funct3[1:0]);
        illegal               = (funct3[2] || funct3[1:0] == 2'b11);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
  end

  assign o_decoded = d;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered, handshaked RV32I decode stage with optional skid entry and flush
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit SKID_ENABLE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  t_data             i_instruction,
  input  t_data             i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output t_data             o_pc,
  output t_register_index   o_source_register1,
  output t_register_index   o_source_register2,
  output t_register_index   o_destination_register,
  output logic              o_destination_register_write_enable,
  output t_alu_operation    o_alu_operation,
  output t_data             o_immediate,
  output logic              o_use_immediate,
  output logic              o_use_pc,
  output t_branch_condition o_branch_condition,
  output logic              o_memory_read_enable,
  output logic              o_memory_write_enable,
  output t_memory_size      o_memory_size,
  output logic              o_memory_unsigned,
  output logic              o_illegal
);

  t_decoded    decoded;
  t_entry      incoming;
  t_entry      main_q, main_d, skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  t_skid_state state_q, state_d;
  logic        in_xfer;

  instruction_decode u_instruction_decode (
    .i_instruction (i_instruction),
    .o_decoded     (decoded)
  );

  assign incoming = '{pc: i_pc, decoded: decoded};
  assign o_ready  = SKID_ENABLE ? (state_q == ST_EMPTY_OR_MAIN) : (!main_valid_q || i_ready);
  assign in_xfer  = i_valid && o_ready && !i_flush;

  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (i_flush) begin
      main_valid_d = 1'b0;
      state_d      = ST_EMPTY_OR_MAIN;
    end else if (main_valid_q && !i_ready) begin
      // Main is held: an accepted instruction can only park in the skid entry.
      if (in_xfer && SKID_ENABLE) begin
        skid_d  = incoming;
        state_d = ST_SKID_FULL;
      end
    end else if (state_q == ST_SKID_FULL) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      state_d      = ST_EMPTY_OR_MAIN;
    end else begin
      main_valid_d = in_xfer;
      if (in_xfer) main_d = incoming;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_EMPTY_OR_MAIN;
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign o_valid                             = main_valid_q;
  assign o_pc                                = main_q.pc;
  assign o_source_register1                  = main_q.decoded.source_register1;
  assign o_source_register2                  = main_q.decoded.source_register2;
  assign o_destination_register              = main_q.decoded.destination_register;
  assign o_destination_register_write_enable = main_q.decoded.destination_register_write_enable;
  assign o_alu_operation                     = main_q.decoded.alu_operation;
  assign o_immediate                         = main_q.decoded.immediate;
  assign o_use_immediate                     = main_q.decoded.use_immediate;
  assign o_use_pc                            = main_q.decoded.use_pc;
  assign o_branch_condition                  = main_q.decoded.branch_condition;
  assign o_memory_read_enable                = main_q.decoded.memory_read_enable;
  assign o_memory_write_enable               = main_q.decoded.memory_write_enable;
  assign o_memory_size                       = main_q.decoded.memory_size;
  assign o_memory_unsigned                   = main_q.decoded.memory_unsigned;
  assign o_illegal                           = main_q.decoded.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench comparing skid and non-skid decode_stage against a queue model
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef logic [63:0] t_q [$];

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        ui, up;
    logic [3:0]  br;
    logic        mr, mw;
    logic [1:0]  sz;
    logic        un, ill;
  } ref_t;

  localparam t_alu_operation ALU_BY_F3 [8] = '{ALU_OP_ADD, ALU_OP_SHIFT_LEFT, ALU_OP_SLT, ALU_OP_SLTU,
                                               ALU_OP_XOR, ALU_OP_SHIFT_RIGHT, ALU_OP_OR, ALU_OP_AND};
  localparam t_branch_condition BR_BY_F3 [8] = '{BRANCH_EQ, BRANCH_NE, BRANCH_NONE, BRANCH_NONE,
                                                 BRANCH_LT, BRANCH_GE, BRANCH_LTU, BRANCH_GEU};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};

  logic i_clk = 1'b0, i_reset = 1'b0, i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [31:0] i_instruction = '0, i_pc = '0, pc_ctr = 32'h1000;

  logic              o_ready [2], o_valid [2], o_we [2], o_ui [2], o_up [2];
  logic              o_mr [2], o_mw [2], o_un [2], o_ill [2];
  t_data             o_pc [2], o_imm [2];
  t_register_index   o_rs1 [2], o_rs2 [2], o_rd [2];
  t_alu_operation    o_alu [2];
  t_branch_condition o_br [2];
  t_memory_size      o_sz [2];

  int n_checks = 0, n_errors = 0, out_cnt0 = 0;
  t_q q0, q1;
  logic acc;

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage #(.SKID_ENABLE(g == 0)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready[g]),
      .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
      .o_valid(o_valid[g]), .i_ready(i_ready), .o_pc(o_pc[g]),
      .o_source_register1(o_rs1[g]), .o_source_register2(o_rs2[g]),
      .o_destination_register(o_rd[g]), .o_destination_register_write_enable(o_we[g]),
      .o_alu_operation(o_alu[g]), .o_immediate(o_imm[g]), .o_use_immediate(o_ui[g]),
      .o_use_pc(o_up[g]), .o_branch_condition(o_br[g]),
      .o_memory_read_enable(o_mr[g]), .o_memory_write_enable(o_mw[g]),
      .o_memory_size(o_sz[g]), .o_memory_unsigned(o_un[g]), .o_illegal(o_ill[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sra(input logic [31:0] w, input int n);
    return 32'($signed(w) >>> n);
  endfunction

  // Reference decoder built from the ISA field rules.
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r = '0;
    bit ok = 1;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [31:0] ii = sra(w, 20);
    logic [31:0] is = (sra(w, 20) & ~32'h1F) | ((w >> 7) & 32'h1F);
    logic [31:0] ib = (sra(w, 19) & 32'hFFFFF000) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
    logic [31:0] iu = w & 32'hFFFFF000;
    logic [31:0] ij = (sra(w, 11) & 32'hFFF00000) | (w & 32'h000FF000) | (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
    case (w[6:0])
      7'h33: begin
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.we = 1; r.alu = ALU_BY_F3[f3];
        if (f7 == 7'h20) begin
          if (f3 == 0) r.alu = ALU_OP_SUB;
          else if (f3 == 5) r.alu = ALU_OP_SHIFT_RIGHT_ARITH;
          else ok = 0;
        end else if (f7 != 0) ok = 0;
      end
      7'h13: begin
        r.rs1 = w[19:15]; r.rd = w[11:7]; r.we = 1; r.ui = 1; r.imm = ii; r.alu = ALU_BY_F3[f3];
        if (f3 == 1) begin ok = (f7 == 0); r.imm = 32'(w[24:20]); end
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20);
          if (f7 == 7'h20) r.alu = ALU_OP_SHIFT_RIGHT_ARITH;
          r.imm = 32'(w[24:20]);
        end
      end
      7'h37, 7'h17: begin
        r.rd = w[11:7]; r.we = 1; r.ui = 1; r.up = (w[6:0] == 7'h17); r.alu = ALU_OP_ADD; r.imm = iu;
      end
      7'h6F: begin
        r.rd = w[11:7]; r.we = 1; r.ui = 1; r.up = 1; r.alu = ALU_OP_ADD; r.imm = ij; r.br = BRANCH_JUMP;
      end
      7'h67: begin
        r.rs1 = w[19:15]; r.rd = w[11:7]; r.we = 1; r.ui = 1; r.alu = ALU_OP_ADD; r.imm = ii;
        r.br = BRANCH_JUMP_REG; ok = (f3 == 0);
      end
      7'h63: begin
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.alu = ALU_OP_SUB; r.imm = ib; r.br = BR_BY_F3[f3];
        ok = (r.br != BRANCH_NONE);
      end
      7'h03: begin
        r.rs1 = w[19:15]; r.rd = w[11:7]; r.we = 1; r.ui = 1; r.alu = ALU_OP_ADD; r.imm = ii;
        r.mr = 1; r.sz = f3[1:0]; r.un = f3[2]; ok = (f3 inside {0, 1, 2, 4, 5});
      end
      7'h23: begin
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.ui = 1; r.alu = ALU_OP_ADD; r.imm = is;
        r.mw = 1; r.sz = f3[1:0]; ok = (f3 < 3);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      r = '0;
      r.ill = 1;
    end
    return r;
  endfunction

  function automatic logic [127:0] observed(input int k);
    return {32'b0, o_pc[k], o_rs1[k], o_rs2[k], o_rd[k], o_we[k], o_alu[k], o_imm[k], o_ui[k], o_up[k],
            o_br[k], o_mr[k], o_mw[k], o_sz[k], o_un[k], o_ill[k]};
  endfunction

  task automatic model_step(input int k, ref t_q q);
    logic ot, it;
    check(k == 0 ? "valid_skid" : "valid_noskid", 128'(o_valid[k]), 128'(q.size() != 0));
    if (k == 0) check("ready_skid", 128'(o_ready[0]), 128'(q.size() < 2));
    else        check("ready_noskid", 128'(o_ready[1]), 128'(q.size() == 0 || i_ready));
    if (o_valid[k] && q.size() != 0)
      check(k == 0 ? "payload_skid" : "payload_noskid", observed(k), {32'b0, q[0][63:32], ref_decode(q[0][31:0])});
    ot = o_valid[k] && i_ready;
    it = i_valid && o_ready[k] && !i_flush;
    if (ot && q.size() != 0) begin
      void'(q.pop_front());
      if (k == 0) out_cnt0++;
    end
    if (i_flush) q.delete();
    if (it) q.push_back({i_pc, i_instruction});
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy, output logic acc0);
    i_valid = v; i_instruction = ins; i_pc = pc_ctr; i_flush = fl; i_ready = rdy;
    pc_ctr = pc_ctr + 4;
    #1;
    acc0 = v && o_ready[0] && !fl;
    model_step(0, q0);
    model_step(1, q1);
    @(negedge i_clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    if ($urandom_range(0, 15) == 0) return $urandom;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), OPS[$urandom_range(0, 9)]};
  endfunction

  initial begin
    logic [31:0] bp [4];
    int idx, start;
    #1 i_reset = 1'b1;
    #1;
    check("reset_valid", 128'(o_valid[0]), 128'(0));
    check("reset_ready", 128'(o_ready[0]), 128'(1));
    check("reset_payload", observed(0), 128'(0));
    @(negedge i_clk);
    i_reset = 1'b0;

    step(1, 32'hFFB10093, 0, 1, acc);
    check("addi_imm", 128'(o_imm[0]), 128'(32'hFFFFFFFB));
    check("addi_alu", 128'(o_alu[0]), 128'(ALU_OP_ADD));
    check("addi_regs", {o_rs1[0], o_rd[0], o_ui[0], o_we[0]}, {5'd2, 5'd1, 1'b1, 1'b1});
    step(1, 32'h40325193, 0, 1, acc);
    check("srai", {o_imm[0], o_alu[0]}, {32'd3, ALU_OP_SHIFT_RIGHT_ARITH});
    step(1, 32'h409403B3, 0, 1, acc);
    check("sub", {o_alu[0], o_rs2[0], o_ui[0]}, {ALU_OP_SUB, 5'd9, 1'b0});
    step(1, 32'h00832283, 0, 1, acc);
    check("lw", {o_mr[0], o_sz[0], o_imm[0], o_un[0]}, {1'b1, MEMORY_SIZE_WORD, 32'd8, 1'b0});
    step(1, 32'h00000000, 0, 1, acc);
    check("zero_illegal", {o_ill[0], o_we[0], o_mr[0], o_mw[0], o_alu[0]}, {1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_INVALID});
    step(0, 0, 0, 1, acc);

    // Backpressure: hold i_ready low from the second cycle, then release.
    for (int i = 0; i < 4; i++) bp[i] = {12'(i + 1), 5'd1, 3'b000, 5'(i + 10), OPCODE_OP_IMM};
    idx = 0;
    start = out_cnt0;
    for (int c = 0; c < 12; c++) begin
      step(idx < 4, idx < 4 ? bp[idx] : 32'h0, 0, c == 0 || c >= 4, acc);
      if (acc) idx++;
      if (c == 1) check("bp_ready_fall", 128'(o_ready[0]), 128'(0));
    end
    check("bp_delivered", 128'(out_cnt0 - start), 128'(4));

    // Flush with both entries full and a third instruction presented.
    step(1, 32'h00100093, 0, 1, acc);
    step(1, 32'h00200113, 0, 0, acc);
    step(1, 32'h00300193, 1, 0, acc);
    check("flush_valid", 128'(o_valid[0]), 128'(0));
    check("flush_ready", 128'(o_ready[0]), 128'(1));
    repeat (3) step(0, 0, 0, 1, acc);

    // Asynchronous reset in the middle of a stalled stream.
    step(1, 32'h00400213, 0, 0, acc);
    step(1, 32'h00500293, 0, 0, acc);
    #2 i_reset = 1'b1;
    #1;
    check("areset_valid", {o_valid[0], o_valid[1]}, 2'b00);
    check("areset_ready", {o_ready[0], o_ready[1]}, 2'b11);
    check("areset_payload", observed(0), 128'(0));
    q0.delete();
    q1.delete();
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int c = 0; c < 800; c++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, acc);
    repeat (4) step(0, 0, 0, 1, acc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
